// File: rtl/decoder_pkg.sv
// Shared types and helpers for the strobe decoder slice.
package decoder_pkg;

    typedef enum logic [1:0] {
        DEC_IDLE = 2'd0,
        DEC_HOLD = 2'd1,
        DEC_SCAN = 2'd2
    } dec_state_t;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned p = 1; p < v; p = p << 1) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/decoder_strobe_seq_if.sv
// Request/strobe bundle for decoder_strobe_seq; err exists only with `DECODER_ERR_EN.
interface decoder_strobe_seq_if #(
    parameter int unsigned SEL_W   = 3,
    parameter int unsigned NUM_OUT = 8
);
    logic               e;
    logic               in_valid;
    logic               in_ready;
    logic [SEL_W-1:0]   in_sel;
    logic               in_scan;
    logic [NUM_OUT-1:0] d;
    logic               busy;
`ifdef DECODER_ERR_EN
    logic               err;

    modport master (output e, in_valid, in_sel, in_scan, input in_ready, d, busy, err);
    modport slave  (input e, in_valid, in_sel, in_scan, output in_ready, d, busy, err);
`else
    modport master (output e, in_valid, in_sel, in_scan, input in_ready, d, busy);
    modport slave  (input e, in_valid, in_sel, in_scan, output in_ready, d, busy);
`endif
endinterface

// File: rtl/decoder_onehot.sv
// Combinational select-to-one-hot; all-zero when disabled or select out of range.
module decoder_onehot #(
    parameter int unsigned SEL_W   = 3,
    parameter int unsigned NUM_OUT = 8
) (
    input  logic               i_e,
    input  logic [SEL_W-1:0]   i_sel,
    output logic [NUM_OUT-1:0] o_onehot
);

    always_comb begin
        o_onehot = '0;
        for (int unsigned i = 0; i < NUM_OUT; i++) begin
            if (i_e && (i_sel == SEL_W'(i))) begin
                o_onehot[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/decoder_strobe_seq.sv
// Registered one-hot strobe generator with hold and scan modes.
// Optional err pulse on out-of-range select when `DECODER_ERR_EN is defined.
module decoder_strobe_seq
    import decoder_pkg::*;
#(
    parameter int unsigned SEL_W     = 3,
    parameter int unsigned NUM_OUT   = 8,
    parameter int unsigned PULSE_LEN = 1
) (
    input logic                clk,
    input logic                rst,
    decoder_strobe_seq_if.slave bus
);

    localparam int unsigned      CNT_W    = clog2(PULSE_LEN + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(PULSE_LEN - 1);
    localparam logic [SEL_W-1:0] IDX_LAST = SEL_W'(NUM_OUT - 1);

    dec_state_t         r_state, w_state_nxt;
    logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
    logic [SEL_W-1:0]   r_idx, w_idx_nxt;
    logic [NUM_OUT-1:0] r_d, w_d_nxt;
    logic [NUM_OUT-1:0] w_onehot;
    logic               w_accept;
    logic               w_err_nxt;

    decoder_onehot #(.SEL_W(SEL_W), .NUM_OUT(NUM_OUT)) u_onehot (
        .i_e      (bus.e),
        .i_sel    (bus.in_sel),
        .o_onehot (w_onehot)
    );

    assign bus.in_ready = bus.e & (r_state == DEC_IDLE);
    assign w_accept     = bus.in_valid & bus.in_ready;
    assign bus.d        = r_d;
    assign bus.busy     = |r_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= DEC_IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_d     <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_idx   <= w_idx_nxt;
            r_d     <= w_d_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_idx_nxt   = r_idx;
        w_d_nxt     = r_d;
        w_err_nxt   = 1'b0;
        if (!bus.e) begin
            w_state_nxt = DEC_IDLE;
            w_cnt_nxt   = '0;
            w_idx_nxt   = '0;
            w_d_nxt     = '0;
        end else begin
            case (r_state)
                DEC_IDLE: begin
                    if (w_accept) begin
                        if (bus.in_scan) begin
                            w_state_nxt = DEC_SCAN;
                            w_idx_nxt   = '0;
                            w_d_nxt     = NUM_OUT'(1);
                            w_cnt_nxt   = CNT_LOAD;
                        end else if (|w_onehot) begin
                            w_state_nxt = DEC_HOLD;
                            w_d_nxt     = w_onehot;
                            w_cnt_nxt   = CNT_LOAD;
                        end else begin
                            // out-of-range select: request consumed, stay idle
                            w_err_nxt = 1'b1;
                        end
                    end
                end
                DEC_HOLD: begin
                    if (r_cnt != '0) begin
                        w_cnt_nxt = r_cnt - CNT_W'(1);
                    end else begin
                        w_state_nxt = DEC_IDLE;
                        w_d_nxt     = '0;
                    end
                end
                DEC_SCAN: begin
                    if (r_cnt != '0) begin
                        w_cnt_nxt = r_cnt - CNT_W'(1);
                    end else if (r_idx != IDX_LAST) begin
                        w_idx_nxt = r_idx + SEL_W'(1);
                        w_d_nxt   = r_d << 1;
                        w_cnt_nxt = CNT_LOAD;
                    end else begin
                        w_state_nxt = DEC_IDLE;
                        w_d_nxt     = '0;
                    end
                end
                default: begin
                    w_state_nxt = DEC_IDLE;
                    w_d_nxt     = '0;
                end
            endcase
        end
    end

`ifdef DECODER_ERR_EN
    logic r_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err <= 1'b0;
        end else begin
            r_err <= w_err_nxt;
        end
    end

    assign bus.err = r_err;
`else
    logic w_err_unused;
    assign w_err_unused = w_err_nxt;
`endif

endmodule
